fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Framebuffer access arbiter between the VGA scan-out path and two game-logic pixel writers (fighter 1 and fighter 2 renderers). It owns the single-port 320x240, 8-bit RRRGGGBB framebuffer RAM and time-slices it. During active video it gives alternate cycles to scan-out reads and to writes; during blanking every cycle is a write slot. It sits between the VGA driver's `next_x`/`next_y`/`color_in` and the renderers.

## Interface
Parameters:
- `ADDR_W`, 17: framebuffer address width.
- `FB_W`, 320: framebuffer width in pixels.
- `FB_DEPTH`, 76800: number of valid framebuffer words.

Ports:
- `clock`  in  1  25 MHz pixel clock; everything in this block is clocked by it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `next_x`  in  10  from the VGA driver; 0..639.
- `next_y`  in  10  from the VGA driver; 0..479.
- `active`  in  1  high while the driver is in active video (both the H and V active states).
- `color_out`  out  8  pixel to the VGA driver `color_in`.
- `frame_start`  out  1  one-cycle pulse at the start of each frame.
- `w0_req`, `w1_req`  in  1  write request; held until granted.
- `w0_addr`, `w1_addr`  in  ADDR_W  write address.
- `w0_data`, `w1_data`  in  8  write data.
- `w0_gnt`, `w1_gnt`  out  1  one-cycle grant pulse.
- `mem_addr`  out  ADDR_W  RAM address (registered).
- `mem_wdata`  out  8  RAM write data (registered).
- `mem_we`  out  1  RAM write enable (registered).
- `mem_rdata`  in  8  RAM read data; valid one cycle after `mem_addr`, because the RAM is synchronous-read.

## Operation
- Slot decision in each cycle t:
  - Read slot if `active`=1 and `next_x[0]`=0.
  - Otherwise write slot.
- Read slot:
  - Scan address = (`next_y`>>1)*FB_W + (`next_x`>>1), computed as (y2<<8)+(y2<<6)+x2 at ADDR_W bits; it never overflows (maximum 76799).
  - `mem_we`=0.
- Write slot with no request: `mem_we`=0 and `mem_addr` holds its previous value.
- Write slot with a request, arbitration:
  - Round-robin between w0 and w1 using a last-granted pointer.
  - A requester whose `gnt` is high in cycle t is masked in cycle t, so the same requester is never granted two cycles in a row.
  - If only the masked requester is asserting, the slot stays idle.
- Grant:
  - Issues `mem_addr`/`mem_wdata` from the winner, with `mem_we`=1, and pulses the winner's `gnt`, all in cycle t+1.
  - Writers must hold `req`/`addr`/`data` stable until they see `gnt`. They may present new data on the cycle after `gnt`.
- Out-of-range writes (`addr` >= FB_DEPTH): the request is granted normally but `mem_we` stays 0, and the pointer still advances.
- Scan-out pipeline:
  - A 2-bit valid/active tag shift register tracks each slot.
  - `color_out` loads `mem_rdata` when a read tag emerges.
  - It loads 8'h00 when the slot issued in that pipeline position had `active`=0.
  - Otherwise `color_out` holds, so each framebuffer pixel is displayed for 2 clocks (2x horizontal scaling). 2x vertical scaling comes from y>>1.
- `frame_start`: registered pulse, high for one cycle when `active` rises while `next_x`=0 and `next_y`=0.

## Timing
- Reset (async, `reset_n`=0): every output is 0, the pipeline tags are cleared, and the pointer is set so w0 has priority first. Any in-flight grant or read is discarded.
- Read latency: decision in t, `mem_addr` in t+1, `mem_rdata` in t+2, `color_out` valid in t+3. The fixed 3-cycle offset is compensated in the top level.
- Write latency: request seen in t, `gnt` + `mem_we` in t+1.
- Throughput:
  - Active video: at most one write per 2 cycles in total.
  - Blanking: one write per cycle when both writers request (alternating); at most one per 2 cycles for a single writer.
- Simultaneous requests with the pointer at w1: w0 wins; then w1, w0, and so on.
- `active` falling mid-line: write slots start from the next cycle, and the in-flight read still completes into `color_out`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs -> all outputs are 0. Release -> still 0 until the first decision propagates.
- Scan-out: preload fb[0]=8'hE0 and fb[1]=8'h1C, set `active`=1, `next_y`=0, step `next_x` 0..3 from cycle 0 -> `color_out`=E0 in cycles 3-4 and 1C in cycles 5-6.
- Corner address: `next_x`=638, `next_y`=479, `active`=1 -> `mem_addr`=76799 with `mem_we`=0 on the next cycle.
- Blanking contention: `active`=0, both `req` held high -> `gnt` sequence w0, w1, w0, w1 on consecutive cycles, `mem_we`=1 every cycle, `mem_addr` following each winner.
- Active, single writer: `active`=1, `w0_req` held high -> `w0_gnt` only in cycles following odd `next_x`, never on two consecutive cycles.
- Out-of-range write: `w1_addr`=76800 with `w1_req`=1 -> `w1_gnt` pulses and `mem_we` stays 0.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: time-slices a single-port framebuffer between VGA scan-out reads
// and two round-robin pixel writers, with a 3-cycle scan-out pipeline.
module fb_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int FB_W     = 320,
  parameter int FB_DEPTH = 76800
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic              active,
  output logic [7:0]        color_out,
  output logic              frame_start,
  input  logic              w0_req,
  input  logic              w1_req,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [7:0]        w0_data,
  input  logic [7:0]        w1_data,
  output logic              w0_gnt,
  output logic              w1_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);
  logic              rd, e0, e1, win, pick1, last, act_q;
  logic [1:0]        tag0, tag1;
  logic [ADDR_W-1:0] scan, waddr;
  logic [7:0]        wdata;
  assign rd    = active & ~next_x[0];
  assign scan  = ADDR_W'(next_y[9:1]) * ADDR_W'(FB_W) + ADDR_W'(next_x[9:1]);
  // a requester granted this cycle is masked so it cannot win back-to-back
  assign e0    = w0_req & ~w0_gnt;
  assign e1    = w1_req & ~w1_gnt;
  assign win   = ~rd & (e0 | e1);
  assign pick1 = e1 & (~e0 | ~last);
  assign waddr = pick1 ? w1_addr : w0_addr;
  assign wdata = pick1 ? w1_data : w0_data;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      w0_gnt      <= 1'b0;
      w1_gnt      <= 1'b0;
      last        <= 1'b1;
      tag0        <= 2'b00;
      tag1        <= 2'b00;
      color_out   <= 8'h00;
      act_q       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      mem_addr    <= rd ? scan : win ? waddr : mem_addr;
      mem_wdata   <= win ? wdata : mem_wdata;
      mem_we      <= win & (waddr < ADDR_W'(FB_DEPTH));
      w0_gnt      <= win & ~pick1;
      w1_gnt      <= win & pick1;
      last        <= win ? pick1 : last;
      tag0        <= {rd, active};
      tag1        <= tag0;
      color_out   <= tag1[1] ? mem_rdata : ~tag1[0] ? 8'h00 : color_out;
      act_q       <= active;
      frame_start <= active & ~act_q & (next_x == 10'd0) & (next_y == 10'd0);
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized bench for fb_arbiter against a slot-level reference
// model that tracks the framebuffer contents and the expected scan-out colour.
module tb_fb_arbiter;
  localparam int DEPTH = 76800;
  localparam int HOLD  = -1;
  localparam int ZERO  = -2;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic [9:0]  next_x = '0, next_y = '0;
  logic        active = 1'b0;
  logic [7:0]  color_out;
  logic        frame_start;
  logic        w0_req = 1'b0, w1_req = 1'b0;
  logic [16:0] w0_addr = '0, w1_addr = '0;
  logic [7:0]  w0_data = '0, w1_data = '0;
  logic        w0_gnt, w1_gnt;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;

  fb_arbiter dut (
    .clock(clock), .reset_n(reset_n), .next_x(next_x), .next_y(next_y),
    .active(active), .color_out(color_out), .frame_start(frame_start),
    .w0_req(w0_req), .w1_req(w1_req), .w0_addr(w0_addr), .w1_addr(w1_addr),
    .w0_data(w0_data), .w1_data(w1_data), .w0_gnt(w0_gnt), .w1_gnt(w1_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #20 clock = ~clock;

  logic [7:0] fb [DEPTH];
  logic [7:0] ref_fb [DEPTH];

  always @(posedge clock) begin
    mem_rdata <= (int'(mem_addr) < DEPTH) ? fb[mem_addr] : 8'h00;
    if (mem_we && int'(mem_addr) < DEPTH) fb[mem_addr] <= mem_wdata;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  int exp_addr, exp_wdata, exp_color, last_w, prev_g;
  bit exp_we, exp_g0, exp_g1, exp_fs, prev_act;
  int color_q[$];

  task automatic model_reset();
    exp_addr = 0; exp_wdata = 0; exp_color = 0; exp_we = 0;
    exp_g0 = 0; exp_g1 = 0; exp_fs = 0;
    last_w = 1; prev_g = -1; prev_act = 0;
    color_q = '{HOLD, HOLD};
  endtask

  // one slot: the winner is the eligible writer that was not granted most recently
  task automatic decide();
    int a, g;
    bit c0, c1;
    g = -1;
    exp_fs = active && !prev_act && next_x == 0 && next_y == 0;
    prev_act = active;
    if (active && next_x % 2 == 0) begin
      a = (int'(next_y) / 2) * 320 + int'(next_x) / 2;
      exp_addr = a;
      exp_we = 0;
      color_q.push_back(int'(ref_fb[a]));
    end else begin
      color_q.push_back(active ? HOLD : ZERO);
      c0 = w0_req && prev_g != 0;
      c1 = w1_req && prev_g != 1;
      if (c0 && c1) g = 1 - last_w;
      else if (c0) g = 0;
      else if (c1) g = 1;
      exp_we = 0;
      if (g >= 0) begin
        last_w = g;
        a = g ? int'(w1_addr) : int'(w0_addr);
        exp_addr = a;
        exp_wdata = g ? int'(w1_data) : int'(w0_data);
        exp_we = a < DEPTH;
        if (exp_we) ref_fb[a] = 8'(exp_wdata);
      end
    end
    prev_g = g;
    exp_g0 = g == 0;
    exp_g1 = g == 1;
  endtask

  task automatic step();
    int v;
    decide();
    @(posedge clock);
    #1;
    v = color_q.pop_front();
    if (v >= 0) exp_color = v;
    else if (v == ZERO) exp_color = 0;
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we", mem_we, exp_we);
    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
    check("w0_gnt", w0_gnt, exp_g0);
    check("w1_gnt", w1_gnt, exp_g1);
    check("frame_start", frame_start, exp_fs);
    check("color_out", color_out, exp_color);
    if (w0_gnt) w0_req = 1'b0;
    if (w1_gnt) w1_req = 1'b0;
  endtask

  task automatic new_req(input int w, input bit oor);
    logic [16:0] a;
    a = oor ? 17'($urandom_range(131071, DEPTH)) : 17'($urandom_range(DEPTH - 1, 0));
    if (w == 0) begin w0_req = 1; w0_addr = a; w0_data = 8'($urandom); end
    else        begin w1_req = 1; w1_addr = a; w1_data = 8'($urandom); end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_color"}, color_out, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_gnt"}, {w0_gnt, w1_gnt}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_we"}, mem_we, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) begin
      next_x = 10'($urandom); next_y = 10'($urandom); active = 1'($urandom);
      w0_req = 1'($urandom); w1_req = 1'($urandom);
      w0_addr = 17'($urandom); w1_addr = 17'($urandom);
      w0_data = 8'($urandom); w1_data = 8'($urandom);
      @(posedge clock);
      #1;
      check_zero("rst");
    end
    next_x = 0; next_y = 0; active = 0; w0_req = 0; w1_req = 0;
    model_reset();
    reset_n = 1'b1;
    #1;
    check_zero("rel");
  endtask

  task automatic random_run(input int n);
    int x, y;
    bit kill;
    x = $urandom_range(799, 0);
    y = $urandom_range(524, 0);
    kill = 0;
    repeat (n) begin
      if ($urandom_range(299, 0) == 0) begin x = 795; y = 524; end
      else if ($urandom_range(299, 0) == 0) begin
        x = $urandom_range(799, 0); y = $urandom_range(524, 0);
      end
      if ($urandom_range(99, 0) == 0) kill = ~kill;
      next_x = 10'(x); next_y = 10'(y);
      active = x < 640 && y < 480 && !kill;
      if (!w0_req && $urandom_range(2, 0) == 0) new_req(0, $urandom_range(7, 0) == 0);
      if (!w1_req && $urandom_range(2, 0) == 0) new_req(1, $urandom_range(7, 0) == 0);
      step();
      x++;
      if (x == 800) begin x = 0; y = (y + 1) % 525; end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      fb[i] = 8'($urandom);
      ref_fb[i] = fb[i];
    end
    fb[0] = 8'hE0; ref_fb[0] = 8'hE0;
    fb[1] = 8'h1C; ref_fb[1] = 8'h1C;
    do_reset();
    active = 1; next_y = 0;
    for (int x = 0; x < 8; x++) begin next_x = 10'(x); step(); end
    next_x = 638; next_y = 479; active = 1;
    step();
    active = 0; next_x = 700; next_y = 10;
    repeat (10) begin
      if (!w0_req) new_req(0, 0);
      if (!w1_req) new_req(1, 0);
      step();
    end
    repeat (3) step();
    next_y = 20;
    for (int x = 0; x < 40; x++) begin
      next_x = 10'(x); active = 1;
      if (!w0_req) new_req(0, 0);
      step();
    end
    active = 0; next_x = 650;
    repeat (3) step();
    w1_req = 1; w1_addr = 17'(DEPTH); w1_data = 8'h5A;
    repeat (3) step();
    random_run(1500);
    do_reset();
    random_run(600);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
